// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 shared constants, round-constant table and schedule helpers
package sha256_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 512;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

  localparam logic [WORD_W-1:0] K_TABLE [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Rotate right by a constant amount (1..31 in practice).
  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha_k_rom.sv
// rtl/sha_k_rom.sv - combinational round-constant lookup, shared with the round controller
module sha_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]        idx,
  output logic [WORD_W-1:0] k
);

  assign k = K_TABLE[idx];

endmodule

// File: rtl/sha_msg_schedule.sv
// rtl/sha_msg_schedule.sv - SHA-256 message schedule producer emitting W_t/K_t per round handshake
module sha_msg_schedule
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
)
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               blk_valid,
  output logic               blk_ready,
  input  logic [BLOCK_W-1:0] blk_data,
  output logic               w_valid,
  input  logic               w_ready,
  output logic [WORD_W-1:0]  w_out,
  output logic [WORD_W-1:0]  k_out,
  output logic [5:0]         round_idx,
  output logic               w_first,
  output logic               w_last
);

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  sched_state_e      state;
  logic [WORD_W-1:0] win [16];
  logic [5:0]        t;
  logic [5:0]        k_idx;
  logic [WORD_W-1:0] k_next;
  logic [WORD_W-1:0] w_new;

  // k_out is registered, so the ROM looks up the constant for the round about to be presented
  always_comb begin
    k_idx = 6'd0;
    if (state == RUN) begin
      k_idx = t + 6'd1;
    end
    w_new = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
  end

  sha_k_rom u_k_rom (
    .idx (k_idx),
    .k   (k_next)
  );

  assign round_idx = t;

  // Load/shift FSM; every output is a register so a stall simply holds all state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      blk_ready <= 1'b1;
      w_valid   <= 1'b0;
      t         <= 6'd0;
      w_first   <= 1'b0;
      w_last    <= 1'b0;
      w_out     <= '0;
      k_out     <= '0;
      for (int i = 0; i < 16; i++) begin
        win[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (blk_valid) begin
            for (int i = 0; i < 16; i++) begin
              win[i] <= blk_data[BLOCK_W-1-WORD_W*i -: WORD_W];
            end
            state     <= RUN;
            blk_ready <= 1'b0;
            w_valid   <= 1'b1;
            t         <= 6'd0;
            w_first   <= 1'b1;
            w_last    <= (LAST == 6'd0);
            w_out     <= blk_data[BLOCK_W-1 -: WORD_W];
            k_out     <= k_next;
          end
        end
        RUN: begin
          if (w_ready) begin
            if (t == LAST) begin
              state     <= IDLE;
              blk_ready <= 1'b1;
              w_valid   <= 1'b0;
              t         <= 6'd0;
              w_first   <= 1'b0;
              w_last    <= 1'b0;
              w_out     <= '0;
              k_out     <= '0;
            end else begin
              for (int i = 0; i < 15; i++) begin
                win[i] <= win[i+1];
              end
              win[15] <= w_new;
              t       <= t + 6'd1;
              w_first <= 1'b0;
              w_last  <= ((t + 6'd1) == LAST);
              w_out   <= win[1];
              k_out   <= k_next;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha_msg_schedule.sv
// tb/tb_sha_msg_schedule.sv - directed self-checking bench for sha_msg_schedule
module tb_sha_msg_schedule;

  localparam int ROUNDS = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         w_valid;
  logic         w_ready;
  logic [31:0]  w_out;
  logic [31:0]  k_out;
  logic [5:0]   round_idx;
  logic         w_first;
  logic         w_last;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_w [64];
  logic [31:0] obs_w [64];

  logic [31:0] kt [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha_msg_schedule #(.ROUNDS(ROUNDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_out     (w_out),
    .k_out     (k_out),
    .round_idx (round_idx),
    .w_first   (w_first),
    .w_last    (w_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  task automatic build_model(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) exp_w[i] = blk[511-32*i -: 32];
    for (int j = 16; j < 64; j++) exp_w[j] = s1(exp_w[j-2]) + exp_w[j-7] + s0(exp_w[j-15]) + exp_w[j-16];
  endtask

  task automatic random_block(output logic [511:0] blk);
    for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_blk_ready"}, {31'b0, blk_ready}, 32'd1);
    check({tag, "_w_valid"}, {31'b0, w_valid}, 32'd0);
    check({tag, "_w_out"}, w_out, 32'd0);
    check({tag, "_k_out"}, k_out, 32'd0);
    check({tag, "_round_idx"}, {26'b0, round_idx}, 32'd0);
    check({tag, "_w_first"}, {31'b0, w_first}, 32'd0);
    check({tag, "_w_last"}, {31'b0, w_last}, 32'd0);
  endtask

  task automatic send_block(input logic [511:0] blk);
    @(negedge clk);
    blk_valid = 1'b1;
    blk_data  = blk;
    w_ready   = 1'b0;
    @(negedge clk);
    check("accept_w_valid", {31'b0, w_valid}, 32'd1);
    blk_valid = 1'b0;
  endtask

  // Entered on the negedge right after acceptance; consumes n_hs rounds against exp_w
  task automatic run_block(input int n_hs, input int stall_pct);
    int hs = 0;
    int cyc = 0;
    bit held = 1'b0;
    logic [31:0] pw, pk;
    logic [5:0] pi;
    while (hs < n_hs && cyc < 1000) begin
      if (held) begin
        check("stall_w", w_out, pw);
        check("stall_k", k_out, pk);
        check("stall_idx", {26'b0, round_idx}, {26'b0, pi});
      end
      if (w_valid) begin
        obs_w[hs] = w_out;
        check($sformatf("w[%0d]", hs), w_out, exp_w[hs]);
        check($sformatf("k[%0d]", hs), k_out, kt[hs]);
        check($sformatf("idx[%0d]", hs), {26'b0, round_idx}, hs);
        check($sformatf("first[%0d]", hs), {31'b0, w_first}, {31'b0, hs == 0});
        check($sformatf("last[%0d]", hs), {31'b0, w_last}, {31'b0, hs == ROUNDS - 1});
        w_ready = ($urandom_range(99) >= stall_pct);
        if (w_ready) begin
          hs++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          pw = w_out;
          pk = k_out;
          pi = round_idx;
        end
      end else begin
        check("w_valid_in_run", {31'b0, w_valid}, 32'd1);
        w_ready = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check("handshake_count", hs, n_hs);
    if (n_hs == ROUNDS) begin
      check("done_blk_ready", {31'b0, blk_ready}, 32'd1);
      check("done_w_valid", {31'b0, w_valid}, 32'd0);
    end
    w_ready = 1'b0;
  endtask

  initial begin
    logic [511:0] abc;
    logic [511:0] blk_a;
    logic [511:0] blk_b;
    int extra;

    abc = {32'h61626380, 448'h0, 32'h00000018};
    rst_n     = 1'b0;
    blk_valid = 1'b0;
    w_ready   = 1'b0;
    blk_data  = '0;

    // reset with random inputs
    repeat (4) begin
      @(negedge clk);
      blk_valid = 1'($urandom);
      w_ready   = 1'($urandom);
      random_block(blk_data);
    end
    check_reset_outputs("rst");
    blk_valid = 1'b0;
    w_ready   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("post_rst");

    // "abc" block, no stalls
    build_model(abc);
    send_block(abc);
    run_block(ROUNDS, 0);
    check("abc_w0", obs_w[0], 32'h61626380);
    check("abc_w15", obs_w[15], 32'h00000018);
    check("abc_w16", obs_w[16], 32'h61626380);
    check("abc_w17", obs_w[17], 32'h000f0000);

    // all-zero block, then verify no extra rounds appear
    build_model('0);
    send_block('0);
    run_block(ROUNDS, 0);
    w_ready = 1'b1;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (w_valid) extra++;
    end
    check("zero_extra_rounds", extra, 0);
    w_ready = 1'b0;

    // random block with ~50% consumer stalls
    random_block(blk_a);
    build_model(blk_a);
    send_block(blk_a);
    run_block(ROUNDS, 50);

    // blk_valid held high across two blocks; data changed mid-run
    random_block(blk_a);
    random_block(blk_b);
    build_model(blk_a);
    @(negedge clk);
    blk_valid = 1'b1;
    blk_data  = blk_a;
    w_ready   = 1'b0;
    @(negedge clk);
    check("hold_accept_a", {31'b0, w_valid}, 32'd1);
    blk_data = blk_b;
    run_block(ROUNDS, 0);
    build_model(blk_b);
    @(negedge clk);
    check("hold_accept_b", {31'b0, w_valid}, 32'd1);
    blk_valid = 1'b0;
    run_block(ROUNDS, 0);

    // reset mid-block at t = 30, then restart
    build_model(abc);
    send_block(abc);
    run_block(30, 0);
    check("mid_idx30", {26'b0, round_idx}, 32'd30);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    send_block(abc);
    run_block(ROUNDS, 0);
    check("restart_w0", obs_w[0], 32'h61626380);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
